// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: frame-synchronous bouncing-sprite position scheduler.
// Moves are computed in shadow registers and committed to the outputs in one cycle.
module sprite_motion_ctrl #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SPRITE_SIZE = 54,
    parameter int FRAME_DIV   = 1,
    parameter int STEP_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              enable,
    input  logic              restart,
    input  logic [STEP_W-1:0] step_x,
    input  logic [STEP_W-1:0] step_y,
    output logic [9:0]        sprite_x,
    output logic [9:0]        sprite_y,
    output logic              dir_x,
    output logic              dir_y,
    output logic              bounce,
    output logic              busy
);
    localparam logic [10:0] X_MAX = 11'(H_RES - SPRITE_SIZE);
    localparam logic [10:0] Y_MAX = 11'(V_RES - SPRITE_SIZE);
    localparam int FW = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;
    localparam logic [1:0] IDLE = 2'd0, CALC_X = 2'd1, CALC_Y = 2'd2, COMMIT = 2'd3;

    logic [1:0]    state;
    logic [FW-1:0] fcnt;
    logic [9:0]    sx, sy;
    logic          flag_x, flag_y;
    logic [10:0]   ex, ey, stx, sty, up_x, up_y;

    assign ex   = {1'b0, sx};
    assign ey   = {1'b0, sy};
    assign stx  = 11'(step_x);
    assign sty  = 11'(step_y);
    assign up_x = ex + stx;
    assign up_y = ey + sty;
    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || restart) begin
            state    <= IDLE;
            fcnt     <= '0;
            sx       <= '0;
            sy       <= '0;
            sprite_x <= '0;
            sprite_y <= '0;
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
            flag_x   <= 1'b0;
            flag_y   <= 1'b0;
            bounce   <= 1'b0;
        end else begin
            bounce <= 1'b0;
            case (state)
                IDLE: if (frame_start && enable) begin
                    if (fcnt == FW'(FRAME_DIV - 1)) begin
                        fcnt  <= '0;
                        state <= CALC_X;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                CALC_X: begin
                    // A zero step parks the axis, even against an edge.
                    if (step_x != '0) begin
                        if (dir_x) begin
                            if (up_x >= X_MAX) begin
                                sx     <= X_MAX[9:0];
                                dir_x  <= 1'b0;
                                flag_x <= 1'b1;
                            end else sx <= up_x[9:0];
                        end else if (ex <= stx) begin
                            sx     <= '0;
                            dir_x  <= 1'b1;
                            flag_x <= 1'b1;
                        end else sx <= sx - 10'(step_x);
                    end
                    state <= CALC_Y;
                end
                CALC_Y: begin
                    if (step_y != '0) begin
                        if (dir_y) begin
                            if (up_y >= Y_MAX) begin
                                sy     <= Y_MAX[9:0];
                                dir_y  <= 1'b0;
                                flag_y <= 1'b1;
                            end else sy <= up_y[9:0];
                        end else if (ey <= sty) begin
                            sy     <= '0;
                            dir_y  <= 1'b1;
                            flag_y <= 1'b1;
                        end else sy <= sy - 10'(step_y);
                    end
                    state <= COMMIT;
                end
                default: begin
                    sprite_x <= sx;
                    sprite_y <= sy;
                    bounce   <= flag_x | flag_y;
                    flag_x   <= 1'b0;
                    flag_y   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed checks of motion, edge bounce, frame division,
// enable gating, restart and asynchronous reset.
module tb_sprite_motion_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       frame_start = 1'b0, enable = 1'b0, restart = 1'b0;
    logic       fs3 = 1'b0, restart3 = 1'b0;
    logic [3:0] step_x = '0, step_y = '0;
    logic [9:0] sprite_x, sprite_y, sprite_x3, sprite_y3;
    logic       dir_x, dir_y, bounce, busy, dir_x3, dir_y3, bounce3, busy3;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    sprite_motion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .enable(enable),
        .restart(restart), .step_x(step_x), .step_y(step_y),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .dir_x(dir_x), .dir_y(dir_y),
        .bounce(bounce), .busy(busy)
    );

    sprite_motion_ctrl #(.FRAME_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .frame_start(fs3), .enable(enable),
        .restart(restart3), .step_x(step_x), .step_y(step_y),
        .sprite_x(sprite_x3), .sprite_y(sprite_y3), .dir_x(dir_x3), .dir_y(dir_y3),
        .bounce(bounce3), .busy(busy3)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ends one ns after the edge that samples the pulse.
    task automatic pulse();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic frame();
        pulse();
        repeat (3) tick();
    endtask

    task automatic frame3();
        tick();
        fs3 = 1'b1;
        tick();
        fs3 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_restart();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_x", sprite_x, 0);
        chk("rst_y", sprite_y, 0);
        chk("rst_dir", {dir_x, dir_y}, 3);
        chk("rst_busy", busy, 0);
        chk("rst_bounce", bounce, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        step_x = 4;
        step_y = 3;

        pulse();
        chk("s1_busy0", busy, 1);
        tick();
        chk("s1_busy1", busy, 1);
        tick();
        chk("s1_busy2", busy, 1);
        tick();
        chk("s1_busy3", busy, 0);
        chk("s1_x", sprite_x, 4);
        chk("s1_y", sprite_y, 3);
        chk("s1_bounce", bounce, 0);
        chk("s1_dir", {dir_x, dir_y}, 3);

        do_restart();
        step_x = 15;
        step_y = 0;
        repeat (39) frame();
        chk("s2_x39", sprite_x, 585);
        chk("s2_dir39", dir_x, 1);
        frame();
        chk("s2_x40", sprite_x, 586);
        chk("s2_dirx40", dir_x, 0);
        chk("s2_bounce40", bounce, 1);
        tick();
        chk("s2_bounce_end", bounce, 0);
        frame();
        chk("s2_x41", sprite_x, 571);
        chk("s2_bounce41", bounce, 0);
        chk("s2_y", sprite_y, 0);
        chk("s2_diry", dir_y, 1);

        do_restart();
        step_x = 0;
        step_y = 5;
        repeat (85) frame();
        chk("s3_y85", sprite_y, 425);
        chk("s3_bounce85", bounce, 0);
        frame();
        chk("s3_y86", sprite_y, 426);
        chk("s3_diry86", dir_y, 0);
        chk("s3_bounce86", bounce, 1);
        chk("s3_x", sprite_x, 0);
        chk("s3_dirx", dir_x, 1);

        step_x = 2;
        step_y = 2;
        for (int i = 1; i <= 2; i++) begin
            tick();
            fs3 = 1'b1;
            tick();
            fs3 = 1'b0;
            chk("s4_busy_skip", busy3, 0);
            repeat (3) tick();
            chk("s4_x_skip", sprite_x3, 0);
        end
        frame3();
        chk("s4_x3", sprite_x3, 2);
        chk("s4_y3", sprite_y3, 2);
        repeat (2) frame3();
        chk("s4_x5", sprite_x3, 2);
        frame3();
        chk("s4_x6", sprite_x3, 4);
        chk("s4_y6", sprite_y3, 4);

        do_restart();
        step_x = 4;
        step_y = 3;
        repeat (2) frame();
        chk("s5_x_pre", sprite_x, 8);
        chk("s5_y_pre", sprite_y, 6);
        enable = 1'b0;
        repeat (5) begin
            pulse();
            chk("s5_busy_dis", busy, 0);
            repeat (3) tick();
        end
        chk("s5_x_dis", sprite_x, 8);
        chk("s5_y_dis", sprite_y, 6);
        enable = 1'b1;
        pulse();
        tick();
        chk("s5_in_calc_y", busy, 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("s5_rs_x", sprite_x, 0);
        chk("s5_rs_y", sprite_y, 0);
        chk("s5_rs_dir", {dir_x, dir_y}, 3);
        chk("s5_rs_busy", busy, 0);
        chk("s5_rs_bounce", bounce, 0);
        repeat (3) tick();
        chk("s5_no_commit", sprite_x, 0);

        frame();
        chk("s6_pre_x", sprite_x, 4);
        pulse();
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_x", sprite_x, 0);
        chk("s6_async_y", sprite_y, 0);
        chk("s6_async_busy", busy, 0);
        chk("s6_async_dir", {dir_x, dir_y}, 3);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("s6_idle_x", sprite_x, 0);
        frame();
        chk("s6_x", sprite_x, 4);
        chk("s6_y", sprite_y, 3);
        chk("s6_bounce", bounce, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
